// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg: active-low seven-segment codes {a,b,c,d,e,f,g} and hex decode
package seg_scan_display_pkg;
  localparam logic [6:0] VAL_0 = 7'b0000001;
  localparam logic [6:0] VAL_1 = 7'b1001111;
  localparam logic [6:0] VAL_2 = 7'b0010010;
  localparam logic [6:0] VAL_3 = 7'b0000110;
  localparam logic [6:0] VAL_4 = 7'b1001100;
  localparam logic [6:0] VAL_5 = 7'b0100100;
  localparam logic [6:0] VAL_6 = 7'b0100000;
  localparam logic [6:0] VAL_7 = 7'b0001111;
  localparam logic [6:0] VAL_8 = 7'b0000000;
  localparam logic [6:0] VAL_9 = 7'b0000100;
  localparam logic [6:0] VAL_A = 7'b0001000;
  localparam logic [6:0] VAL_B = 7'b1100000;
  localparam logic [6:0] VAL_C = 7'b0110001;
  localparam logic [6:0] VAL_D = 7'b1000010;
  localparam logic [6:0] VAL_E = 7'b0110000;
  localparam logic [6:0] VAL_F = 7'b0111000;
  localparam logic [6:0] VAL_BLANK = 7'b1111111;
  localparam logic [6:0] VAL_DEF = 7'b1111110;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = VAL_0;
      4'h1: hex_to_seg = VAL_1;
      4'h2: hex_to_seg = VAL_2;
      4'h3: hex_to_seg = VAL_3;
      4'h4: hex_to_seg = VAL_4;
      4'h5: hex_to_seg = VAL_5;
      4'h6: hex_to_seg = VAL_6;
      4'h7: hex_to_seg = VAL_7;
      4'h8: hex_to_seg = VAL_8;
      4'h9: hex_to_seg = VAL_9;
      4'hA: hex_to_seg = VAL_A;
      4'hB: hex_to_seg = VAL_B;
      4'hC: hex_to_seg = VAL_C;
      4'hD: hex_to_seg = VAL_D;
      4'hE: hex_to_seg = VAL_E;
      4'hF: hex_to_seg = VAL_F;
      default: hex_to_seg = VAL_DEF;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: display request inputs and active-low pin outputs
interface seg_scan_display_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0] dp_in;
  logic [DIGITS-1:0] digit_en;
  logic blank_lz;
  logic [3:0] bright;
  logic [DIGITS-1:0] seg_C;
  logic [6:0] a_to_g;
  logic dp;
  modport master(output num, dp_in, digit_en, blank_lz, bright, input seg_C, a_to_g, dp);
  modport slave(input num, dp_in, digit_en, blank_lz, bright, output seg_C, a_to_g, dp);
endinterface

// File: rtl/seg_scan_display_seg_decoder.sv
// seg_decoder: combinational hex nibble to active-low segment pattern
module seg_decoder
  import seg_scan_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg(nib_i);
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed hex display with frame snapshot, LZ blanking, PWM and guard cycle
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg_scan_display_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] TOP = IW'(DIGITS - 1);
  localparam logic [PW:0] SLICE = (PW + 1)'(CLK_DIV / 16);

  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic prime_q;
  logic [4*DIGITS-1:0] num_q;
  logic [DIGITS-1:0] dpi_q, en_q, lz, seg_c_q, seg_c_d;
  logic blz_q, tick, snap, lit, blank, z, dp_q, dp_d;
  logic [3:0] bright_q, nib;
  logic [PW:0] lim;
  logic [6:0] dec, atog_q, atog_d;

  seg_decoder u_dec (.nib_i(nib), .seg_o(dec));

  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z = z && (num_q[4*k +: 4] == 4'h0);
      lz[k] = blz_q && z;
    end
  end

  // prime_q makes the first tick after reset a snapshot so the scan restarts at the leftmost digit
  always_comb begin
    tick = pre_q == PW'(CLK_DIV - 1);
    snap = tick && (prime_q || idx_q == '0);
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = snap ? TOP : tick ? idx_q - 1'b1 : idx_q;
    nib = num_q[4*idx_q +: 4];
    lim = (PW + 1)'({1'b0, bright_q} + 5'd1) * SLICE + (PW + 1)'(1);
    lit = en_q[idx_q] && pre_q != '0 && {1'b0, pre_q} < lim;
    blank = lz[idx_q];
    seg_c_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
    atog_d = blank ? VAL_BLANK : dec;
    dp_d = blank | ~dpi_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= TOP;
      prime_q <= 1'b1;
      num_q <= '0;
      dpi_q <= '0;
      en_q <= '0;
      blz_q <= 1'b0;
      bright_q <= '0;
      seg_c_q <= '1;
      atog_q <= VAL_BLANK;
      dp_q <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      prime_q <= prime_q && !tick;
      seg_c_q <= seg_c_d;
      atog_q <= atog_d;
      dp_q <= dp_d;
      if (snap) begin
        num_q <= bus.num;
        dpi_q <= bus.dp_in;
        en_q <= bus.digit_en;
        blz_q <= bus.blank_lz;
        bright_q <= bus.bright;
      end
    end
  end

  assign bus.seg_C = seg_c_q;
  assign bus.a_to_g = atog_q;
  assign bus.dp = dp_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed scenario bench for seg_scan_display at DIGITS=4, CLK_DIV=16
module tb_seg_scan_display;
  localparam int DIGITS = 4;
  localparam int CLK_DIV = 16;
  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C1 = 7'b1001111;
  localparam logic [6:0] C2 = 7'b0010010;
  localparam logic [6:0] C4 = 7'b1001100;
  localparam logic [6:0] CA = 7'b0001000;
  localparam logic [6:0] CF = 7'b0111000;
  localparam logic [6:0] CB = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_display_if #(.DIGITS(DIGITS)) bus ();
  seg_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] cap_seg[200];
  logic [6:0] cap_ag[200];
  logic cap_dp[200];
  logic [3:0] r_seg;
  logic [6:0] r_ag;
  logic r_dp;
  logic [3:0] sel[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  task automatic set_in(input logic [15:0] n, input logic [3:0] en, input logic [3:0] dpi,
                        input logic [3:0] br, input logic blz);
    bus.num = n;
    bus.digit_en = en;
    bus.dp_in = dpi;
    bus.bright = br;
    bus.blank_lz = blz;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_seg = bus.seg_C;
    r_ag = bus.a_to_g;
    r_dp = bus.dp;
    rst = 1'b0;
  endtask

  // index i holds outputs after the (i+1)th edge following reset; slot s cycle c is at 16+16*s+c
  task automatic capture(input int n, input int chg_at, input logic [15:0] chg_num);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cap_seg[i] = bus.seg_C;
      cap_ag[i] = bus.a_to_g;
      cap_dp[i] = bus.dp;
      if (i == chg_at) bus.num = chg_num;
    end
  endtask

  function automatic int lows(input int base);
    int c = 0;
    for (int i = 0; i < 16; i++) if (cap_seg[base+i] !== 4'hF) c++;
    return c;
  endfunction

  function automatic int dp_lows(input int base);
    int c = 0;
    for (int i = 0; i < 16; i++) if (cap_dp[base+i] !== 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    int lit;
    set_in(16'h12AF, 4'hF, 4'hF, 4'hF, 1'b0);
    apply_reset();
    n_cmp++; if (r_seg !== 4'hF) begin n_bad++; $display("FAIL reset_seg got %b want 1111", r_seg); end
    n_cmp++; if (r_ag !== CB) begin n_bad++; $display("FAIL reset_ag got %b want %b", r_ag, CB); end
    n_cmp++; if (r_dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", r_dp); end
    capture(18, -1, 16'h0);
    lit = 0;
    for (int i = 0; i < 17; i++) if (cap_seg[i] !== 4'hF) lit++;
    n_cmp++; if (lit !== 0) begin n_bad++; $display("FAIL reset_dark lit=%0d want 0", lit); end
    n_cmp++; if (cap_seg[17] !== 4'b0111) begin n_bad++; $display("FAIL reset_first_lit got %b want 0111", cap_seg[17]); end
  endtask

  task automatic test_basic_scan();
    logic [6:0] ea[4] = '{C1, C2, CA, CF};
    set_in(16'h12AF, 4'hF, 4'h0, 4'hF, 1'b0);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (cap_seg[b] !== 4'hF) begin n_bad++; $display("FAIL scan_guard s%0d got %b want 1111", s, cap_seg[b]); end
      n_cmp++; if (cap_seg[b+1] !== sel[s]) begin n_bad++; $display("FAIL scan_sel s%0d got %b want %b", s, cap_seg[b+1], sel[s]); end
      n_cmp++; if (lows(b) !== 15) begin n_bad++; $display("FAIL scan_on s%0d got %0d want 15", s, lows(b)); end
      n_cmp++; if (cap_ag[b+1] !== ea[s]) begin n_bad++; $display("FAIL scan_ag s%0d got %b want %b", s, cap_ag[b+1], ea[s]); end
      n_cmp++; if (cap_dp[b+7] !== 1'b1) begin n_bad++; $display("FAIL scan_dp s%0d got %b want 1", s, cap_dp[b+7]); end
    end
  endtask

  task automatic test_lz_blanking();
    logic [6:0] e1[4] = '{CB, CB, C4, C0};
    logic [6:0] e2[4] = '{CB, CB, CB, C0};
    set_in(16'h0040, 4'hF, 4'hF, 4'hF, 1'b1);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (cap_ag[b+3] !== e1[s]) begin n_bad++; $display("FAIL lz_ag s%0d got %b want %b", s, cap_ag[b+3], e1[s]); end
      n_cmp++; if (cap_seg[b+3] !== sel[s]) begin n_bad++; $display("FAIL lz_sel s%0d got %b want %b", s, cap_seg[b+3], sel[s]); end
      n_cmp++; if (cap_dp[b+3] !== (s < 2)) begin n_bad++; $display("FAIL lz_dp s%0d got %b want %b", s, cap_dp[b+3], s < 2); end
    end
    set_in(16'h0000, 4'hF, 4'h0, 4'hF, 1'b1);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (cap_ag[b+3] !== e2[s]) begin n_bad++; $display("FAIL lz0_ag s%0d got %b want %b", s, cap_ag[b+3], e2[s]); end
    end
  endtask

  task automatic test_brightness();
    set_in(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (lows(b) !== 1) begin n_bad++; $display("FAIL br0_on s%0d got %0d want 1", s, lows(b)); end
      n_cmp++; if (cap_seg[b+1] !== sel[s]) begin n_bad++; $display("FAIL br0_pre1 s%0d got %b want %b", s, cap_seg[b+1], sel[s]); end
    end
    set_in(16'h1234, 4'hF, 4'h0, 4'h7, 1'b0);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (lows(b) !== 8) begin n_bad++; $display("FAIL br7_on s%0d got %0d want 8", s, lows(b)); end
      n_cmp++; if (cap_seg[b+8] !== sel[s]) begin n_bad++; $display("FAIL br7_pre8 s%0d got %b want %b", s, cap_seg[b+8], sel[s]); end
      n_cmp++; if (cap_seg[b+9] !== 4'hF) begin n_bad++; $display("FAIL br7_pre9 s%0d got %b want 1111", s, cap_seg[b+9]); end
    end
  endtask

  task automatic test_enable_dp();
    int eon[4] = '{15, 0, 15, 0};
    int edp[4] = '{0, 0, 16, 0};
    set_in(16'h1234, 4'b1010, 4'b0010, 4'hF, 1'b0);
    apply_reset();
    capture(80, -1, 16'h0);
    for (int s = 0; s < 4; s++) begin
      int b = 16 + 16 * s;
      n_cmp++; if (lows(b) !== eon[s]) begin n_bad++; $display("FAIL en_on s%0d got %0d want %0d", s, lows(b), eon[s]); end
      n_cmp++; if (dp_lows(b) !== edp[s]) begin n_bad++; $display("FAIL dp_on s%0d got %0d want %0d", s, dp_lows(b), edp[s]); end
    end
  endtask

  task automatic test_snapshot();
    set_in(16'h1111, 4'hF, 4'h0, 4'hF, 1'b0);
    apply_reset();
    capture(144, 37, 16'h2222);
    n_cmp++; if (cap_ag[42] !== C1) begin n_bad++; $display("FAIL snap_mid got %b want %b", cap_ag[42], C1); end
    for (int s = 0; s < 4; s++) begin
      n_cmp++; if (cap_ag[16+16*s+1] !== C1) begin n_bad++; $display("FAIL snap_old s%0d got %b want %b", s, cap_ag[16+16*s+1], C1); end
      n_cmp++; if (cap_ag[80+16*s+1] !== C2) begin n_bad++; $display("FAIL snap_new s%0d got %b want %b", s, cap_ag[80+16*s+1], C2); end
    end
  endtask

  task automatic test_reset_mid();
    int lit;
    set_in(16'h12AF, 4'hF, 4'hF, 4'hF, 1'b0);
    apply_reset();
    capture(54, -1, 16'h0);
    n_cmp++; if (cap_seg[53] !== 4'b1101) begin n_bad++; $display("FAIL mid_pre got %b want 1101", cap_seg[53]); end
    apply_reset();
    n_cmp++; if (r_seg !== 4'hF) begin n_bad++; $display("FAIL mid_seg got %b want 1111", r_seg); end
    n_cmp++; if (r_ag !== CB) begin n_bad++; $display("FAIL mid_ag got %b want %b", r_ag, CB); end
    n_cmp++; if (r_dp !== 1'b1) begin n_bad++; $display("FAIL mid_dp got %b want 1", r_dp); end
    capture(40, -1, 16'h0);
    lit = 0;
    for (int i = 0; i < 17; i++) if (cap_seg[i] !== 4'hF) lit++;
    n_cmp++; if (lit !== 0) begin n_bad++; $display("FAIL mid_dark lit=%0d want 0", lit); end
    n_cmp++; if (cap_seg[17] !== 4'b0111) begin n_bad++; $display("FAIL mid_restart got %b want 0111", cap_seg[17]); end
    n_cmp++; if (cap_ag[17] !== C1) begin n_bad++; $display("FAIL mid_restart_ag got %b want %b", cap_ag[17], C1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    set_in(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    test_reset();
    test_basic_scan();
    test_lz_blanking();
    test_brightness();
    test_enable_dp();
    test_snapshot();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment driver for the board display. It time-multiplexes `DIGITS` hex digits onto one shared segment bus and adds several features:
- a programmable refresh prescaler
- per-digit enable
- optional leading-zero blanking
- decimal points
- 16-level PWM brightness
- anti-ghosting blank slots

It sits at the top level between the CPU debug/register-view mux and the board pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned, 1..8.
- `CLK_DIV`, 100000: clk cycles per digit slot; ≥16 and a multiple of 16.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high; acts on the next `clk` edge.
- `num` in 4*DIGITS: hex value. Digit k is `num[4k+3:4k]`; k=DIGITS-1 is leftmost.
- `dp_in` in DIGITS: decimal point request per digit, 1 = lit.
- `digit_en` in DIGITS: 1 = digit k may light.
- `blank_lz` in 1: 1 = blank leading zero digits.
- `bright` in 4: brightness level 0..15.
- `seg_C` out DIGITS: digit select, active-low; bit k selects digit k.
- `a_to_g` out 7: segment pattern, active-low, encoded per shared segment codes.
- `dp` out 1: decimal point, active-low.

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1 and wraps; `tick` = (`pre`==CLK_DIV-1).
- Slot index `idx` scans DIGITS-1 down to 0 (leftmost first) and advances on `tick`. From 0 it wraps to DIGITS-1.
- Frame snapshot: on the `tick` that loads `idx`=DIGITS-1, the block registers `num`, `dp_in`, `digit_en`, `blank_lz` and `bright` into shadow registers. The whole frame displays from the shadow, so there is no tearing mid-frame.
- Leading-zero blanking: digit k is blank when shadow `blank_lz`=1, k≠0, and all nibbles DIGITS-1..k are zero. Digit 0 is never LZ-blanked. A blanked digit drives `a_to_g`=VAL_BLANK and `dp`=1, but its `seg_C` bit may still assert.
- Lighting: `seg_C[idx]`=0 only when `digit_en[idx]`=1, `pre`≥1 (the guard slot) and `pre` < 1 + (bright+1)*(CLK_DIV/16). Otherwise `seg_C`=all ones. `bright`=15 gives full slot minus one cycle.
- `a_to_g` = decode(nibble[idx]) unless blanked. `dp` = ~dp_in[idx] unless blanked.
- Hex decode covers 0..F. The default arm is unreachable but must drive VAL_DEF.

## Timing
- All outputs are registered.
- Reset values:
  - `seg_C`=all ones, `a_to_g`=VAL_BLANK, `dp`=1.
  - `pre`=0, `idx`=DIGITS-1.
  - Shadow registers are cleared: num=0, dp=0, en=0, bright=0, blank_lz=0.
- Reset mid-scan blanks the display from the edge after `rst` sampled high.
- After reset deasserts, the first tick (CLK_DIV cycles later) loads a snapshot. The display is dark until then because shadow en=0.
- Slot change: on the cycle `pre` wraps to 0, `seg_C` is all ones. This is one guard cycle for anti-ghosting.
- Output latency: one cycle after `pre`/`idx` update.
- Input changes take effect at the next frame start, at most DIGITS*CLK_DIV cycles later.
- Simultaneous events:
  - `rst` dominates `tick`.
  - The snapshot tick and the idx wrap coincide by construction.
- DIGITS=1: `idx` is constant at 0; a snapshot loads every tick.
- Widths:
  - `pre` width = $clog2(CLK_DIV).
  - The brightness compare is done in that width plus 1 bit, so there is no overflow at bright=15.

## Structure
- Shared definitions file holds:
  - segment codes VAL_0..VAL_F, VAL_BLANK (7'b1111111), VAL_DEF
  - the hex→segment decode function
- Sub-module `seg_decoder`: combinational 4-bit → 7-bit using the shared codes. It is instantiated once on the selected nibble.
- The prescaler, scan counter, shadow regs, LZ logic and PWM compare live in `seg_scan_display`.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=16 unless stated.
- **Basic scan:** `num`=16'h12AF, en=4'hF, bright=15, blank_lz=0.
  - Slots run in order digit3..0.
  - `seg_C` shows 0111, 1011, 1101, 1110, each low for 15 of 16 cycles.
  - `a_to_g` shows VAL_1, VAL_2, VAL_A, VAL_F.
  - `seg_C`=1111 on each slot's cycle 0.
- **LZ blanking:** `num`=16'h0040, blank_lz=1.
  - Digits 3 and 2 show VAL_BLANK.
  - Digit 1 shows VAL_4, digit 0 shows VAL_0.
  - With `num`=0, only digit 0 shows VAL_0.
- **Brightness:** bright=0 → each `seg_C` bit low for exactly 1 cycle per slot (`pre`=1); bright=7 → low for 8 cycles (`pre`=1..8).
- **Enable/dp:** en=4'b1010, dp_in=4'b0010.
  - Digits 2 and 0 are never selected.
  - `dp`=0 only during digit 1's slot.
- **Snapshot coherence:** change `num` from 16'h1111 to 16'h2222 during digit 2's slot. The remaining slots of that frame still show VAL_1; the next frame shows VAL_2 on all digits.
- **Reset mid-frame:** assert `rst` during digit 1.
  - Next edge: `seg_C`=1111, `a_to_g`=VAL_BLANK, `dp`=1.
  - After release: dark for 16 cycles, then the scan restarts at digit 3.
